// File: rtl/pmp_scan_ctrl_pkg.sv
// Shared PMP types and CSR map for pmp_scan_ctrl.
// cfg_legalize() honours the optional PMP_LOCK_EN macro when deciding whether L is stored.
package cep_define;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    typedef enum logic [1:0] {
        ACC_R    = 2'b00,
        ACC_W    = 2'b01,
        ACC_X    = 2'b10,
        ACC_NONE = 2'b11
    } acc_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

    // Reserved bits read as zero and the reserved W-without-R combination collapses to no access.
    function automatic pmp_cfg_t cfg_legalize(input logic [7:0] b);
        pmp_cfg_t c;
        c      = pmp_cfg_t'(b);
        c.rsvd = 2'b00;
        c.w    = c.w & c.r;
`ifndef PMP_LOCK_EN
        c.l    = 1'b0;
`endif
        return c;
    endfunction

endpackage

// File: rtl/pmp_scan_ctrl_match.sv
// Per-entry PMP address matcher: compares a sized access against one entry's region.
// Addresses are widened by two bits so pmpaddr << 2 never overflows.
module pmp_scan_ctrl_match
    import cep_define::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] addr_n,
    input  logic [XLEN-1:0] addr_n_1,
    input  logic [1:0]      size,
    input  pmp_a_e          a,
    output logic            match
);
    localparam int AW = XLEN + 2;

    logic [AW-1:0] acc_lo;
    logic [AW-1:0] acc_hi;
    logic [AW-1:0] top;
    logic [AW-1:0] bot;
    logic [AW-1:0] napot_mask;

    always_comb begin
        acc_lo     = {2'b00, addr};
        acc_hi     = acc_lo + ((AW'(1) << size) - AW'(1));
        top        = {addr_n, 2'b00};
        bot        = {addr_n_1, 2'b00};
        // Trailing ones of pmpaddr plus the next bit give the NAPOT size; low two bits are implied.
        napot_mask = {addr_n ^ (addr_n + XLEN'(1)), 2'b11};
        match      = 1'b0;
        case (a)
            A_TOR:   match = (acc_lo >= bot) && (acc_hi < top);
            A_NA4:   match = (acc_lo[AW-1:2] == top[AW-1:2]) && (acc_hi[AW-1:2] == top[AW-1:2]);
            A_NAPOT: match = ((acc_lo & ~napot_mask) == (top & ~napot_mask)) &&
                             ((acc_hi & ~napot_mask) == (top & ~napot_mask));
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_scan_ctrl.sv
// PMP CSR owner and sequential permission checker (lowest entry first, first hit wins).
// Optional macro PMP_LOCK_EN enables sticky L bits, write protection and M-mode enforcement.
module pmp_scan_ctrl
    import cep_define::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            chk_req,
    input  logic [XLEN-1:0] chk_addr,
    input  logic [1:0]      chk_size,
    input  logic [1:0]      chk_type,
    input  logic            chk_priv_m,
    output logic            chk_busy,
    output logic            chk_done,
    output logic            chk_allow,
    output logic            chk_hit,
    output logic [3:0]      chk_hit_idx,
    output logic [1:0]      dbg_state
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    // Handshake: chk_req is taken only while chk_busy is low; the result is valid in the single
    // cycle chk_done is high and chk_allow/chk_hit/chk_hit_idx hold until the next chk_done.

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  load, finish;
    logic [XLEN-1:0]       lat_addr;
    logic [1:0]            lat_size;
    acc_type_e             lat_type;
    logic                  lat_priv;
    pmp_cfg_t              cfg_q   [NUM_ENTRIES];
    logic [XLEN-1:0]       paddr_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] cfg_lock, addr_lock;
    logic [XLEN-1:0]       addr_n, addr_n_1;
    logic                  ent_match, perm, res_allow;
    logic                  allow_q, hit_q;
    logic [3:0]            hit_idx_q;

`ifdef PMP_LOCK_EN
    always_comb begin
        cfg_lock = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) cfg_lock[i] = cfg_q[i].l;
        addr_lock = cfg_lock;
        // A locked TOR entry also freezes the address that forms its lower bound.
        for (int i = 1; i < NUM_ENTRIES; i++)
            if (cfg_q[i].l && cfg_q[i].a == A_TOR) addr_lock[i-1] = 1'b1;
    end
`else
    assign cfg_lock  = '0;
    assign addr_lock = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cfg_q[i]   <= '0;
                paddr_q[i] <= '0;
            end
        end else if (csr_we) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (csr_addr == PMPCFG_BASE + 12'(i / 4) && !cfg_lock[i])
                    cfg_q[i] <= cfg_legalize(csr_wdata[8*(i%4) +: 8]);
                if (csr_addr == PMPADDR_BASE + 12'(i) && !addr_lock[i])
                    paddr_q[i] <= csr_wdata;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (csr_addr == PMPCFG_BASE + 12'(i / 4)) csr_rdata[8*(i%4) +: 8] = cfg_q[i];
            if (csr_addr == PMPADDR_BASE + 12'(i))    csr_rdata = paddr_q[i];
        end
    end

    always_comb begin
        addr_n   = paddr_q[idx_q];
        addr_n_1 = '0;
        if (idx_q != '0) addr_n_1 = paddr_q[idx_q - IDX_W'(1)];
    end

    pmp_scan_ctrl_match #(
        .XLEN(XLEN)
    ) u_match (
        .addr    (lat_addr),
        .addr_n  (addr_n),
        .addr_n_1(addr_n_1),
        .size    (lat_size),
        .a       (cfg_q[idx_q].a),
        .match   (ent_match)
    );

    always_comb begin
        perm = 1'b0;
        case (lat_type)
            ACC_R:   perm = cfg_q[idx_q].r;
            ACC_W:   perm = cfg_q[idx_q].w;
            ACC_X:   perm = cfg_q[idx_q].x;
            default: perm = 1'b0;
        endcase
`ifdef PMP_LOCK_EN
        if (ent_match) res_allow = (lat_priv && !cfg_q[idx_q].l) ? 1'b1 : perm;
        else           res_allow = lat_priv;
`else
        if (lat_priv)  res_allow = 1'b1;
        else           res_allow = ent_match & perm;
`endif
        if (lat_type == ACC_NONE) res_allow = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (chk_req) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (ent_match || idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            lat_addr  <= '0;
            lat_size  <= '0;
            lat_type  <= ACC_R;
            lat_priv  <= 1'b0;
            allow_q   <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                lat_addr <= chk_addr;
                lat_size <= chk_size;
                lat_type <= acc_type_e'(chk_type);
                lat_priv <= chk_priv_m;
            end
            if (finish) begin
                allow_q   <= res_allow;
                hit_q     <= ent_match;
                hit_idx_q <= ent_match ? 4'(idx_q) : 4'd0;
            end
        end
    end

    assign chk_busy    = (state_q != ST_IDLE);
    assign chk_done    = (state_q == ST_DONE);
    assign chk_allow   = allow_q;
    assign chk_hit     = hit_q;
    assign chk_hit_idx = hit_idx_q;
    assign dbg_state   = state_q;

endmodule
